// File: rtl/i2c_accel_sequencer.sv
// ============================================================================
// i2c_accel_sequencer
// ----------------------------------------------------------------------------
// Purpose:
//   Command sequencer that sits directly upstream of the I2C_Bus master.
//   After a start pulse it writes a fixed 3-entry accelerometer init list.
//   It then polls the three XYZ data bytes every POLL_DIV clocks. Each poll
//   is a pointer write {addrW, DATA_REG} followed by a 3-byte read. Every
//   good sample is presented with a 1-cycle valid strobe.
//
// Build option:
//   ACCEL_RETRY_EN  When defined, a NACKed or timed-out transaction is
//                   reissued up to MAX_RETRY times before fault is raised.
//                   When undefined, the first error raises fault and the
//                   sequencer returns to IDLE.
//
// Ports:
//   clk_in       in   1   bus clock, shared with I2C_Bus
//   reset        in   1   asynchronous, active-high reset
//   start        in   1   1-cycle pulse; starts init from IDLE only
//   halt         in   1   level; finish the current transaction, then IDLE
//   I2C_en       out  1   transaction enable, held high until I2C_done
//   I2C_wr       out  1   0 = write, 1 = read
//   I2C_wdata    out  32  write bytes, MSB-first; first byte at [(NM-1)*8+7 -: 8]
//   I2C_rdata    out  32  read command bytes, same packing
//   I2C_NM       out  5   byte count including the address byte
//   I2C_done     in   1   1-cycle pulse at stop
//   I2C_error    in   1   NACK seen; meaningful while I2C_en is high
//   ReadData     in   24  {X,Y,Z}; valid in the cycle after I2C_done
//   accel_data   out  24  last good {X,Y,Z} sample
//   accel_valid  out  1   1-cycle strobe when accel_data updates
//   init_done    out  1   high once all init writes have been ACKed
//   fault        out  1   sticky error flag, cleared only by reset
//   nack_count   out  8   saturating count of NACKed or timed-out transactions
// ============================================================================
module i2c_accel_sequencer #(
    parameter logic [6:0]  CHIP_ADDR    = 7'h1D,
    parameter logic [7:0]  DATA_REG     = 8'h01,
    parameter logic [15:0] POLL_DIV     = 16'd4000,
    parameter logic [15:0] DONE_TIMEOUT = 16'd2000,
    parameter logic [1:0]  MAX_RETRY    = 2'd3
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        start,
    input  logic        halt,
    output logic        I2C_en,
    output logic        I2C_wr,
    output logic [31:0] I2C_wdata,
    output logic [31:0] I2C_rdata,
    output logic [4:0]  I2C_NM,
    input  logic        I2C_done,
    input  logic        I2C_error,
    input  logic [23:0] ReadData,
    output logic [23:0] accel_data,
    output logic        accel_valid,
    output logic        init_done,
    output logic        fault,
    output logic [7:0]  nack_count
);

`ifdef ACCEL_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam logic [7:0] ADDR_W = {CHIP_ADDR, 1'b0};
    localparam logic [7:0] ADDR_R = {CHIP_ADDR, 1'b1};

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT_ISSUE,
        ST_INIT_WAIT,
        ST_GAP,
        ST_POLL_GAP,
        ST_PTR_ISSUE,
        ST_PTR_WAIT,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_LATCH,
        ST_ERR_HANDLE
    } state_t;

    // Kind of transaction that GAP leads into (also the one to reissue on retry).
    typedef enum logic [1:0] {
        OP_INIT,
        OP_PTR,
        OP_RD
    } op_t;

    // Init write list: {pad, addrW, register, value}, sent with NM = 3.
    function automatic logic [31:0] init_rom(input logic [1:0] idx);
        logic [31:0] word;
        case (idx)
            2'd0:    word = {8'h00, ADDR_W, 8'h2A, 8'h00};  // standby
            2'd1:    word = {8'h00, ADDR_W, 8'h0E, 8'h00};  // +-2 g range
            default: word = {8'h00, ADDR_W, 8'h2A, 8'h01};  // active
        endcase
        return word;
    endfunction

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  retry_q, retry_d;
    logic [15:0] tmo_q, tmo_d;
    logic [15:0] poll_q, poll_d;
    logic        poll_run_q, poll_run_d;
    logic        err_flag_q, err_flag_d;
    logic        en_q, en_d;
    logic        wr_q, wr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  nm_q, nm_d;
    logic [23:0] accel_data_q, accel_data_d;
    logic        accel_valid_q, accel_valid_d;
    logic        init_done_q, init_done_d;
    logic        fault_q, fault_d;
    logic [7:0]  nack_q, nack_d;

    // A done only counts while we are actually driving a transaction.
    logic done_seen;
    logic txn_err;
    logic tmo_hit;
    logic poll_wrap;

    assign done_seen = I2C_done && en_q;
    assign txn_err   = err_flag_q || I2C_error;
    assign tmo_hit   = (tmo_q == DONE_TIMEOUT - 16'd1);
    assign poll_wrap = (poll_q == POLL_DIV - 16'd1);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_INIT;
            idx_q         <= 2'd0;
            retry_q       <= 2'd0;
            tmo_q         <= 16'd0;
            poll_q        <= 16'd0;
            poll_run_q    <= 1'b0;
            err_flag_q    <= 1'b0;
            en_q          <= 1'b0;
            wr_q          <= 1'b0;
            wdata_q       <= 32'd0;
            rdata_q       <= 32'd0;
            nm_q          <= 5'd0;
            accel_data_q  <= 24'd0;
            accel_valid_q <= 1'b0;
            init_done_q   <= 1'b0;
            fault_q       <= 1'b0;
            nack_q        <= 8'd0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            idx_q         <= idx_d;
            retry_q       <= retry_d;
            tmo_q         <= tmo_d;
            poll_q        <= poll_d;
            poll_run_q    <= poll_run_d;
            err_flag_q    <= err_flag_d;
            en_q          <= en_d;
            wr_q          <= wr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            nm_q          <= nm_d;
            accel_data_q  <= accel_data_d;
            accel_valid_q <= accel_valid_d;
            init_done_q   <= init_done_d;
            fault_q       <= fault_d;
            nack_q        <= nack_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        idx_d         = idx_q;
        retry_d       = retry_q;
        tmo_d         = tmo_q;
        poll_d        = poll_q;
        poll_run_d    = poll_run_q;
        err_flag_d    = err_flag_q;
        en_d          = en_q;
        wr_d          = wr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        nm_d          = nm_q;
        accel_data_d  = accel_data_q;
        accel_valid_d = 1'b0;
        init_done_d   = init_done_q;
        fault_d       = fault_q;
        nack_d        = nack_q;

        // The poll timer runs regardless of bus activity. A slot that passes
        // while a transaction is in flight is simply missed.
        if (poll_run_q) begin
            poll_d = poll_wrap ? 16'd0 : poll_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !fault_q) begin
                    idx_d   = 2'd0;
                    retry_d = 2'd0;
                    op_d    = OP_INIT;
                    state_d = ST_INIT_ISSUE;
                end
            end

            // Issue states load the bus outputs on the same edge that raises
            // I2C_en. They stay frozen until en drops again.
            ST_INIT_ISSUE: begin
                en_d       = 1'b1;
                wr_d       = 1'b0;
                nm_d       = 5'd3;
                wdata_d    = init_rom(idx_q);
                rdata_d    = 32'd0;
                err_flag_d = 1'b0;
                tmo_d      = 16'd0;
                op_d       = OP_INIT;
                state_d    = ST_INIT_WAIT;
            end

            ST_PTR_ISSUE: begin
                en_d       = 1'b1;
                wr_d       = 1'b0;
                nm_d       = 5'd2;
                wdata_d    = {16'h0000, ADDR_W, DATA_REG};
                rdata_d    = 32'd0;
                err_flag_d = 1'b0;
                tmo_d      = 16'd0;
                op_d       = OP_PTR;
                state_d    = ST_PTR_WAIT;
            end

            ST_RD_ISSUE: begin
                en_d       = 1'b1;
                wr_d       = 1'b1;
                nm_d       = 5'd4;
                wdata_d    = 32'd0;
                rdata_d    = {ADDR_R, 24'h000000};
                err_flag_d = 1'b0;
                tmo_d      = 16'd0;
                op_d       = OP_RD;
                state_d    = ST_RD_WAIT;
            end

            ST_INIT_WAIT, ST_PTR_WAIT, ST_RD_WAIT: begin
                // A NACK may be flagged at any point of the enable window,
                // so it is accumulated and judged when done arrives.
                err_flag_d = err_flag_q || I2C_error;
                tmo_d      = tmo_q + 16'd1;
                if (done_seen) begin
                    en_d = 1'b0;
                    if (txn_err) begin
                        state_d = ST_ERR_HANDLE;
                    end else begin
                        retry_d = 2'd0;
                        case (state_q)
                            ST_INIT_WAIT: begin
                                if (idx_q == 2'd2) begin
                                    init_done_d = 1'b1;
                                    poll_d      = 16'd0;
                                    poll_run_d  = 1'b1;
                                    state_d     = halt ? ST_IDLE : ST_POLL_GAP;
                                end else begin
                                    idx_d   = idx_q + 2'd1;
                                    op_d    = OP_INIT;
                                    state_d = halt ? ST_IDLE : ST_GAP;
                                end
                            end
                            ST_PTR_WAIT: begin
                                op_d    = OP_RD;
                                state_d = halt ? ST_IDLE : ST_GAP;
                            end
                            default: begin
                                // Read data only becomes valid one cycle later;
                                // halt is honoured after the sample is out.
                                state_d = ST_RD_LATCH;
                            end
                        endcase
                    end
                end else if (tmo_hit) begin
                    en_d    = 1'b0;
                    state_d = ST_ERR_HANDLE;
                end
            end

            ST_RD_LATCH: begin
                accel_data_d  = ReadData;
                accel_valid_d = 1'b1;
                state_d       = halt ? ST_IDLE : ST_POLL_GAP;
            end

            // Single cycle here plus the issue cycle gives the two en-low
            // clocks the bus needs to clear its byte counters.
            ST_GAP: begin
                if (halt) begin
                    state_d = ST_IDLE;
                end else begin
                    case (op_q)
                        OP_PTR:  state_d = ST_PTR_ISSUE;
                        OP_RD:   state_d = ST_RD_ISSUE;
                        default: state_d = ST_INIT_ISSUE;
                    endcase
                end
            end

            ST_POLL_GAP: begin
                if (halt) begin
                    state_d = ST_IDLE;
                end else if (poll_wrap) begin
                    state_d = ST_PTR_ISSUE;
                end
            end

            ST_ERR_HANDLE: begin
                en_d   = 1'b0;
                nack_d = (nack_q == 8'hFF) ? nack_q : nack_q + 8'd1;
                if (RETRY_EN && (retry_q < MAX_RETRY)) begin
                    // op_q still names the failed transaction, so GAP reissues it.
                    retry_d = retry_q + 2'd1;
                    state_d = halt ? ST_IDLE : ST_GAP;
                end else begin
                    fault_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                en_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // Entering or sitting in IDLE: bus released, polling stopped,
        // init must be redone on the next start.
        if (state_d == ST_IDLE) begin
            en_d        = 1'b0;
            init_done_d = 1'b0;
            poll_run_d  = 1'b0;
        end
    end

    assign I2C_en      = en_q;
    assign I2C_wr      = wr_q;
    assign I2C_wdata   = wdata_q;
    assign I2C_rdata   = rdata_q;
    assign I2C_NM      = nm_q;
    assign accel_data  = accel_data_q;
    assign accel_valid = accel_valid_q;
    assign init_done   = init_done_q;
    assign fault       = fault_q;
    assign nack_count  = nack_q;

endmodule

// File: tb/tb_i2c_accel_sequencer.sv
// ============================================================================
// tb_i2c_accel_sequencer
// ----------------------------------------------------------------------------
// Directed bench for i2c_accel_sequencer. A small I2C_Bus model answers every
// enable with done after a fixed latency. It can NACK a chosen transaction or
// hang. Expected transactions and samples are queued by the stimulus and
// checked as the sequencer produces them.
// ============================================================================
module tb_i2c_accel_sequencer;

    localparam int LAT = 4;  // bus-model clocks from en rise to done

    logic        clk_in = 1'b0;
    logic        reset;
    logic        start;
    logic        halt;
    logic        I2C_en;
    logic        I2C_wr;
    logic [31:0] I2C_wdata;
    logic [31:0] I2C_rdata;
    logic [4:0]  I2C_NM;
    logic        I2C_done  = 1'b0;
    logic        I2C_error = 1'b0;
    logic [23:0] ReadData  = 24'h0;
    logic [23:0] accel_data;
    logic        accel_valid;
    logic        init_done;
    logic        fault;
    logic [7:0]  nack_count;

    i2c_accel_sequencer dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .start      (start),
        .halt       (halt),
        .I2C_en     (I2C_en),
        .I2C_wr     (I2C_wr),
        .I2C_wdata  (I2C_wdata),
        .I2C_rdata  (I2C_rdata),
        .I2C_NM     (I2C_NM),
        .I2C_done   (I2C_done),
        .I2C_error  (I2C_error),
        .ReadData   (ReadData),
        .accel_data (accel_data),
        .accel_valid(accel_valid),
        .init_done  (init_done),
        .fault      (fault),
        .nack_count (nack_count)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        wr;
        logic [4:0]  nm;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gap;     // required en-low clocks before this txn (0 = unchecked)
        int          period;  // required clocks since previous read start (0 = unchecked)
    } txn_t;

    txn_t        exp_q[$];
    logic [23:0] smp_q[$];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int target   = 0;

    // Bus model state
    bit          hang      = 1'b0;
    int          nack_on   = -1;
    int          txn_cnt   = 0;
    int          valid_cnt = 0;
    int          high_run  = 0;
    int          low_run   = 0;
    int          last_rd   = 0;
    logic [23:0] rd_value  = 24'h0;
    logic        en_prev   = 1'b0;
    logic        valid_prev = 1'b0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk(input logic wr, input logic [4:0] nm, input logic [31:0] wd,
                                input logic [31:0] rd, input int gap, input int period);
        txn_t t;
        t.wr = wr; t.nm = nm; t.wdata = wd; t.rdata = rd; t.gap = gap; t.period = period;
        return t;
    endfunction

    task automatic push_init(input int g0);
        exp_q.push_back(mk(1'b0, 5'd3, 32'h003A2A00, 32'h0, g0, 0));
        exp_q.push_back(mk(1'b0, 5'd3, 32'h003A0E00, 32'h0, 2, 0));
        exp_q.push_back(mk(1'b0, 5'd3, 32'h003A2A01, 32'h0, 2, 0));
    endtask

    task automatic push_poll(input logic [23:0] v, input int period);
        exp_q.push_back(mk(1'b0, 5'd2, 32'h00003A01, 32'h0, 0, 0));
        exp_q.push_back(mk(1'b1, 5'd4, 32'h0, 32'h3B000000, 2, period));
        smp_q.push_back(v);
    endtask

    // Bus model and output monitor, evaluated away from the active edge.
    always @(negedge clk_in) begin
        txn_t e;
        if (I2C_en && !en_prev) begin
            n_assert++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_txn: observed wdata 0x%08h rdata 0x%08h expected no transaction",
                       I2C_wdata, I2C_rdata);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("txn_wr", {31'd0, I2C_wr}, {31'd0, e.wr});
                chk("txn_nm", {27'd0, I2C_NM}, {27'd0, e.nm});
                chk("txn_wdata", I2C_wdata, e.wdata);
                chk("txn_rdata", I2C_rdata, e.rdata);
                if (e.gap != 0) chk("en_low_gap", low_run, e.gap);
                if (e.period != 0) chk("read_period", cyc - last_rd, e.period);
            end
            if (I2C_wr) last_rd = cyc;
            txn_cnt++;
            high_run = 0;
        end
        if (!I2C_en && en_prev && hang) chk("timeout_len", high_run, 2000);

        // ReadData is meaningful only in the cycle after done.
        ReadData = I2C_done ? rd_value : 24'h0BAD0B;

        if (I2C_en) begin
            high_run++;
            low_run = 0;
            if (!hang && high_run == LAT) begin
                I2C_done  = 1'b1;
                I2C_error = (txn_cnt - 1 == nack_on);
            end else begin
                I2C_done  = 1'b0;
                I2C_error = 1'b0;
            end
        end else begin
            low_run++;
            I2C_done  = 1'b0;
            I2C_error = 1'b0;
        end
        en_prev = I2C_en;

        if (accel_valid) begin
            valid_cnt++;
            n_assert++;
            assert (!valid_prev) else begin
                n_fail++;
                $error("FAIL valid_width: observed 2-cycle accel_valid expected 1-cycle");
            end
            n_assert++;
            assert (smp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_sample: observed 0x%06h expected no sample", accel_data);
            end
            if (smp_q.size() != 0) chk("accel_data", {8'd0, accel_data}, {8'd0, smp_q.pop_front()});
        end
        valid_prev = accel_valid;
    end

    function automatic bit cond(input int code);
        case (code)
            0:       return init_done;
            1:       return fault;
            2:       return valid_cnt >= target;
            default: return txn_cnt >= target;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int code, input int bound);
        int n = 0;
        while (!cond(code) && n < bound) begin
            @(negedge clk_in);
            n++;
        end
        n_assert++;
        assert (cond(code)) else begin
            n_fail++;
            $error("FAIL %s: observed no event after %0d cycles expected within %0d", tag, n, bound);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_en"},    {31'd0, I2C_en},      32'd0);
        chk({tag, "_wr"},    {31'd0, I2C_wr},      32'd0);
        chk({tag, "_wdata"}, I2C_wdata,            32'd0);
        chk({tag, "_rdata"}, I2C_rdata,            32'd0);
        chk({tag, "_nm"},    {27'd0, I2C_NM},      32'd0);
        chk({tag, "_data"},  {8'd0, accel_data},   32'd0);
        chk({tag, "_valid"}, {31'd0, accel_valid}, 32'd0);
        chk({tag, "_init"},  {31'd0, init_done},   32'd0);
        chk({tag, "_fault"}, {31'd0, fault},       32'd0);
        chk({tag, "_nack"},  {24'd0, nack_count},  32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
    endtask

    initial begin
        int base;
        reset = 1'b1;
        start = 1'b0;
        halt  = 1'b0;
        repeat (3) @(negedge clk_in);
        check_reset("rst");
        reset = 1'b0;
        @(negedge clk_in);

        // T1: init write list
        push_init(0);
        pulse_start();
        wait_for("t1_init_done", 0, 200);
        chk("t1_nack", {24'd0, nack_count}, 32'd0);
        chk("t1_fault", {31'd0, fault}, 32'd0);
        chk("t1_queue", exp_q.size(), 32'd0);

        // T2: two polls, second read 4000 clocks after the first
        rd_value = 24'h12F0A5;
        push_poll(24'h12F0A5, 0);
        target = valid_cnt + 1;
        wait_for("t2_sample1", 2, 6000);
        chk("t2_data1", {8'd0, accel_data}, 32'h0012F0A5);
        rd_value = 24'h345678;
        push_poll(24'h345678, 4000);
        target = valid_cnt + 1;
        wait_for("t2_sample2", 2, 6000);

        // T5: halt during the read, sample still delivered, then IDLE
        rd_value = 24'hABCDEF;
        push_poll(24'hABCDEF, 4000);
        target = txn_cnt + 2;
        wait_for("t5_rd_start", 3, 6000);
        halt = 1'b1;
        target = valid_cnt + 1;
        wait_for("t5_sample", 2, 50);
        repeat (3) @(negedge clk_in);
        chk("t5_en", {31'd0, I2C_en}, 32'd0);
        chk("t5_init", {31'd0, init_done}, 32'd0);
        base = txn_cnt;
        repeat (4100) @(negedge clk_in);
        chk("t5_no_poll", txn_cnt, base);
        halt = 1'b0;

        // T3: NACK on init entry 1
        nack_on = txn_cnt + 1;
        exp_q.push_back(mk(1'b0, 5'd3, 32'h003A2A00, 32'h0, 0, 0));
        exp_q.push_back(mk(1'b0, 5'd3, 32'h003A0E00, 32'h0, 2, 0));
`ifdef ACCEL_RETRY_EN
        exp_q.push_back(mk(1'b0, 5'd3, 32'h003A0E00, 32'h0, 0, 0));
        exp_q.push_back(mk(1'b0, 5'd3, 32'h003A2A01, 32'h0, 2, 0));
        pulse_start();
        wait_for("t3_init_done", 0, 300);
        chk("t3_nack", {24'd0, nack_count}, 32'd1);
        chk("t3_fault", {31'd0, fault}, 32'd0);
        halt = 1'b1;
        repeat (3) @(negedge clk_in);
        chk("t3_en", {31'd0, I2C_en}, 32'd0);
        chk("t3_init", {31'd0, init_done}, 32'd0);
        halt = 1'b0;
`else
        pulse_start();
        wait_for("t3_fault", 1, 300);
        repeat (2) @(negedge clk_in);
        chk("t3_fault", {31'd0, fault}, 32'd1);
        chk("t3_en", {31'd0, I2C_en}, 32'd0);
        chk("t3_nack", {24'd0, nack_count}, 32'd1);
        chk("t3_init", {31'd0, init_done}, 32'd0);
`endif
        chk("t3_queue", exp_q.size(), 32'd0);
        nack_on = -1;

        // T4: bus never answers
        reset = 1'b1;
        @(negedge clk_in);
        check_reset("t4_rst");
        reset = 1'b0;
        @(negedge clk_in);
        hang = 1'b1;
`ifdef ACCEL_RETRY_EN
        repeat (4) exp_q.push_back(mk(1'b0, 5'd3, 32'h003A2A00, 32'h0, 0, 0));
`else
        exp_q.push_back(mk(1'b0, 5'd3, 32'h003A2A00, 32'h0, 0, 0));
`endif
        pulse_start();
        wait_for("t4_fault", 1, 10000);
        @(negedge clk_in);
`ifdef ACCEL_RETRY_EN
        chk("t4_nack", {24'd0, nack_count}, 32'd4);
`else
        chk("t4_nack", {24'd0, nack_count}, 32'd1);
`endif
        chk("t4_en", {31'd0, I2C_en}, 32'd0);
        chk("t4_queue", exp_q.size(), 32'd0);
        base = txn_cnt;
        pulse_start();
        repeat (20) @(negedge clk_in);
        chk("t4_start_blocked", txn_cnt, base);
        hang = 1'b0;

        // T6: reset in the middle of a transaction, then a clean re-run
        reset = 1'b1;
        @(negedge clk_in);
        reset = 1'b0;
        @(negedge clk_in);
        push_init(0);
        pulse_start();
        target = txn_cnt + 1;
        wait_for("t6_txn_start", 3, 50);
        @(negedge clk_in);
        chk("t6_en_before", {31'd0, I2C_en}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_en", {31'd0, I2C_en}, 32'd0);
        chk("t6_nm", {27'd0, I2C_NM}, 32'd0);
        chk("t6_wdata", I2C_wdata, 32'd0);
        exp_q.delete();
        @(negedge clk_in);
        reset = 1'b0;
        @(negedge clk_in);
        push_init(0);
        pulse_start();
        wait_for("t6_init_done", 0, 300);
        chk("t6_queue", exp_q.size(), 32'd0);
        halt = 1'b1;
        repeat (3) @(negedge clk_in);
        chk("t6_halt_en", {31'd0, I2C_en}, 32'd0);
        halt = 1'b0;
        repeat (5) @(negedge clk_in);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
